// File: rtl/taus_pkg.sv
// Shared definitions for the taus_gen requester side.
//   fetch_state_t : request FSM states used by taus_fetch
//   SEED_S1..S3   : default generator seeds (shared with generator and models)
//   RAND_W        : random sample width
package taus_pkg;

  localparam int RAND_W = 32;

  localparam logic [RAND_W-1:0] SEED_S1 = 32'hffffffff;
  localparam logic [RAND_W-1:0] SEED_S2 = 32'hcccccccc;
  localparam logic [RAND_W-1:0] SEED_S3 = 32'h00ff00ff;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WARM = 2'd1,
    S_RUN  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/taus_fifo.sv
// Sample buffer for taus_fetch: DEPTH x RAND_W, synchronous write/read,
// combinational head.
//   clk, reset_n : clock, asynchronous active-low reset
//   wr_en/wr_data: push one sample (ignored only if full with no read)
//   rd_en        : pop head (ignored while empty)
//   head/valid   : head entry (0 while empty) and non-empty flag
//   count        : occupancy 0..DEPTH
module taus_fifo
  import taus_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [RAND_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [RAND_W-1:0] head,
  output logic              valid,
  output logic [AW:0]       count
);

  logic [RAND_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              rd_ok;
  logic              wr_ok;

  assign valid = (count != '0);
  assign rd_ok = rd_en && valid;
  assign wr_ok = wr_en && ((count != (AW+1)'(DEPTH)) || rd_ok);

  // Head is forced to zero while empty so the output is defined out of reset.
  assign head = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/taus_fetch.sv
// Requester for the taus_gen rand_gen/rand_valid interface. Issues request
// pulses, captures each sample one cycle later, discards the first WARMUP
// samples after reset, then buffers samples for a valid/ready consumer.
//   clk, reset_n   : clock, asynchronous active-low reset
//   enable         : permits new generator requests
//   gen_rand_gen   : request pulse to the generator
//   gen_random_num : generator sample, valid the cycle after a request
//   gen_rand_valid : generator valid flag, expected high on every capture
//   m_data/m_valid/m_ready : downstream stream (head of buffer)
//   fill_level     : buffer occupancy 0..DEPTH
//   warmup_done    : sticky, warm-up samples all discarded
//   proto_err      : sticky, a capture saw gen_rand_valid low
module taus_fetch
  import taus_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int WARMUP = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic              gen_rand_gen,
  input  logic [RAND_W-1:0] gen_random_num,
  input  logic              gen_rand_valid,
  output logic [RAND_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [AW:0]       fill_level,
  output logic              warmup_done,
  output logic              proto_err
);

  localparam int WCW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

  fetch_state_t   state;
  fetch_state_t   state_nxt;
  logic           req_d;
  logic [WCW-1:0] issued_warm;
  logic [WCW-1:0] cap_warm;
  logic           pop;
  logic           wr_en;
  logic           cap_last;
  logic [AW+1:0]  credit;

  assign pop = m_valid && m_ready;

  // Slots committed next cycle: current entries plus the in-flight sample,
  // minus the entry leaving now. A request is only made if this leaves room.
  assign credit = {1'b0, fill_level} + (AW+2)'(req_d) - (AW+2)'(pop);

  // Captures outside warm-up always land in the buffer, including the one
  // still in flight when the FSM has just dropped back to idle.
  assign wr_en    = req_d && (state != S_WARM);
  assign cap_last = req_d && (state == S_WARM) && (cap_warm == WCW'(WARMUP - 1));

  always_comb begin
    state_nxt    = state;
    gen_rand_gen = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) state_nxt = ((WARMUP > 0) && !warmup_done) ? S_WARM : S_RUN;
      end
      S_WARM: begin
        gen_rand_gen = enable && (issued_warm < WCW'(WARMUP));
        if (cap_last) state_nxt = S_RUN;
      end
      S_RUN: begin
        gen_rand_gen = enable && (credit < (AW+2)'(DEPTH));
        if (!enable) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      req_d       <= 1'b0;
      issued_warm <= '0;
      cap_warm    <= '0;
      warmup_done <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      req_d <= gen_rand_gen;
      if (gen_rand_gen && (state == S_WARM)) issued_warm <= issued_warm + WCW'(1);
      if (req_d && (state == S_WARM))        cap_warm    <= cap_warm + WCW'(1);
      if (cap_last)                          warmup_done <= 1'b1;
      if (req_d && !gen_rand_valid)          proto_err   <= 1'b1;
    end
  end

  taus_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (gen_random_num),
    .rd_en   (pop),
    .head    (m_data),
    .valid   (m_valid),
    .count   (fill_level)
  );

endmodule

// File: tb/tb_taus_fetch.sv
// Self-checking bench for taus_fetch with a behavioural taus88 generator.
module tb_taus_fetch;
  import taus_pkg::*;

  localparam int DEPTH  = 8;
  localparam int WARMUP = 16;
  localparam int NEXP   = 4096;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        gen_rand_gen;
  logic [31:0] gen_random_num;
  logic        gen_rand_valid;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [3:0]  fill_level;
  logic        warmup_done;
  logic        proto_err;

  logic        force_bad = 1'b0;
  logic [95:0] gen_s;
  logic [31:0] exp_seq [NEXP];

  int n_cmp = 0;
  int n_bad = 0;
  int req_cnt = 0;
  int pop_cnt = 0;
  int idx = WARMUP;
  int caps;
  bit wd_seen = 1'b0;
  logic req_m;

  always #5 clk = ~clk;

  taus_fetch #(
    .DEPTH  (DEPTH),
    .WARMUP (WARMUP)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .gen_rand_gen   (gen_rand_gen),
    .gen_random_num (gen_random_num),
    .gen_rand_valid (gen_rand_valid),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .fill_level     (fill_level),
    .warmup_done    (warmup_done),
    .proto_err      (proto_err)
  );

  function automatic logic [95:0] taus_step(input logic [95:0] s);
    logic [31:0] a, b, c, t;
    a = s[95:64]; b = s[63:32]; c = s[31:0];
    t = ((a << 13) ^ a) >> 19; a = ((a & 32'hFFFFFFFE) << 12) ^ t;
    t = ((b << 2)  ^ b) >> 25; b = ((b & 32'hFFFFFFF8) << 4)  ^ t;
    t = ((c << 3)  ^ c) >> 11; c = ((c & 32'hFFFFFFF0) << 17) ^ t;
    return {a, b, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Generator: one registered sample per request, reset with the requester.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gen_s          <= {SEED_S1, SEED_S2, SEED_S3};
      gen_random_num <= '0;
      gen_rand_valid <= 1'b0;
    end else begin
      gen_rand_valid <= gen_rand_gen && !force_bad;
      if (gen_rand_gen) begin
        gen_s          <= taus_step(gen_s);
        gen_random_num <= taus_step(gen_s)[95:64] ^ taus_step(gen_s)[63:32] ^ taus_step(gen_s)[31:0];
      end
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_m <= 1'b0;
      caps  <= 0;
    end else begin
      req_m <= gen_rand_gen;
      if (req_m) caps <= caps + 1;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (warmup_done && !wd_seen) begin
        wd_seen = 1'b1;
        chk("warmup_rise_caps", caps, WARMUP);
      end
      chk("fill_bound", 32'(fill_level <= DEPTH), 1);
      if (gen_rand_gen) begin
        req_cnt++;
        chk("credit", 32'((int'(fill_level) + int'(req_m) - int'(m_valid && m_ready)) < DEPTH), 1);
      end
      if (m_valid && m_ready) begin
        if (idx < NEXP) chk("pop_data", m_data, exp_seq[idx]);
        idx++;
        pop_cnt++;
      end
    end
  end

  task automatic wait_fill(input int target, input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (fill_level == 4'(target)) break;
    end
    chk(tag, fill_level, target);
  endtask

  task automatic wait_gen(input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (gen_rand_gen) break;
    end
    chk(tag, gen_rand_gen, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gen"},   gen_rand_gen, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_data"},  m_data, 0);
    chk({tag, "_fill"},  fill_level, 0);
    chk({tag, "_wdone"}, warmup_done, 0);
    chk({tag, "_perr"},  proto_err, 0);
  endtask

  initial begin
    int r0;
    int p0;
    logic [95:0] s;
    s = {SEED_S1, SEED_S2, SEED_S3};
    for (int i = 0; i < NEXP; i++) begin
      s = taus_step(s);
      exp_seq[i] = s[95:64] ^ s[63:32] ^ s[31:0];
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");

    // Warm-up and initial fill with no consumer
    @(posedge clk); #1;
    reset_n = 1'b1;
    enable  = 1'b1;
    wait_fill(8, 200, "first_fill");
    repeat (10) @(negedge clk);
    chk("first_req_total", req_cnt, 24);
    chk("first_fill_hold", fill_level, 8);
    chk("first_wdone", warmup_done, 1);
    chk("first_head", m_data, exp_seq[16]);
    chk("first_mvalid", m_valid, 1);
    chk("first_perr", proto_err, 0);

    // Continuous consumer
    @(posedge clk); #1;
    m_ready = 1'b1;
    p0 = pop_cnt;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (pop_cnt - p0 >= 1000) break;
    end
    chk("stream_1000", 32'(pop_cnt - p0 >= 1000), 1);
    r0 = req_cnt;
    repeat (50) @(negedge clk);
    chk("sustain_reqs", req_cnt - r0, 50);

    // Random backpressure
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      m_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    m_ready = 1'b0;
    wait_fill(8, 50, "refill_after_rand");

    // Drain while disabled, then drop enable right after a request
    @(posedge clk); #1;
    enable  = 1'b0;
    m_ready = 1'b1;
    wait_fill(0, 50, "drain_idle");
    @(posedge clk); #1;
    m_ready = 1'b0;
    r0 = req_cnt;
    repeat (5) @(negedge clk);
    chk("idle_no_req", req_cnt - r0, 0);
    chk("idle_wdone", warmup_done, 1);
    @(posedge clk); #1;
    enable = 1'b1;
    wait_gen(10, "reenable_req");
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("drop_fill", fill_level, 1);
    chk("drop_reqs", req_cnt - r0, 1);
    @(posedge clk); #1;
    enable = 1'b1;
    wait_fill(8, 50, "resume_fill");
    repeat (5) @(negedge clk);
    chk("resume_reqs", req_cnt - r0, 8);

    // Protocol error on a capture
    chk("perr_before", proto_err, 0);
    @(posedge clk); #1;
    force_bad = 1'b1;
    m_ready   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    force_bad = 1'b0;
    m_ready   = 1'b0;
    repeat (3) @(negedge clk);
    chk("perr_set", proto_err, 1);
    wait_fill(8, 50, "perr_refill");
    repeat (20) @(negedge clk);
    chk("perr_sticky", proto_err, 1);

    // Reset with 5 entries and a request outstanding
    @(posedge clk); #1;
    enable  = 1'b0;
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_fill4", fill_level, 4);
    @(posedge clk); #1;
    enable = 1'b1;
    wait_gen(10, "pre_rst_req");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_fill5", fill_level, 5);
    chk("pre_rst_inflight", req_m, 1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    req_cnt = 0;
    idx     = WARMUP;
    wd_seen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_fill(8, 200, "post_rst_fill");
    repeat (10) @(negedge clk);
    chk("post_rst_reqs", req_cnt, 24);
    chk("post_rst_head", m_data, exp_seq[16]);
    chk("post_rst_wdone", warmup_done, 1);
    chk("post_rst_perr", proto_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/taus_fetch.md
Name: taus_fetch

Overview:
- Consumer/requester side of the taus_gen rand_gen/rand_valid interface.
- Drives rand_gen and captures random_num one cycle after each request.
- Discards a configurable warm-up run of samples, then buffers samples in a small FIFO.
- Serves downstream logic (Box-Muller / noise injectors) over a valid/ready stream.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2
- WARMUP, 16, samples discarded after reset before any sample is buffered; 0 allowed
- AW, $clog2(DEPTH), FIFO pointer width (derived, not overridden)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  permits new requests to the generator
- gen_rand_gen  out  1  request pulse to taus_gen.rand_gen
- gen_random_num  in  32  taus_gen.random_num
- gen_rand_valid  in  1  taus_gen.rand_valid
- m_data  out  32  head-of-FIFO sample
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  downstream accept
- fill_level  out  AW+1  current FIFO occupancy, 0..DEPTH
- warmup_done  out  1  warm-up complete; sticky until reset
- proto_err  out  1  sticky: capture cycle seen with gen_rand_valid low

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n).
- Reset values:
  - gen_rand_gen=0, m_valid=0, m_data=0, fill_level=0, warmup_done=0, proto_err=0.
  - FSM=S_IDLE, warm-up counter=0, pointers=0, req_d=0.
- Generator timing:
  - A request in cycle t (gen_rand_gen=1) yields a new sample on gen_random_num in cycle t+1.
  - req_d is gen_rand_gen registered; capture occurs in every cycle with req_d=1.
  - Back-to-back requests are legal: one new sample per cycle.
- Capture and error:
  - A capture with gen_rand_valid=0 sets proto_err.
  - The sample is still treated as consumed (counted or written).
- FSM states:
  - S_IDLE: no requests. enable=1 goes to S_WARM if WARMUP>0 and warmup_done=0; otherwise to S_RUN.
  - S_WARM: gen_rand_gen = enable && (issued_warm < WARMUP).
    - Captures increment the warm-up counter and are never written to the FIFO.
    - When the WARMUP-th capture lands: set warmup_done, go to S_RUN.
    - Total warm-up requests are exactly WARMUP; no excess request is issued.
  - S_RUN: gen_rand_gen = enable && (fill_level + req_d - pop < DEPTH), where pop = m_valid && m_ready.
    - This guarantees an in-flight sample always has a free slot, so there is no overflow.
    - enable=0 goes to S_IDLE. A pending capture (req_d=1) still completes into the FIFO.
  - Warm-up runs once per reset. Later enable toggles go S_IDLE<->S_RUN directly.
- FIFO:
  - Write on capture in S_RUN; read on pop. Simultaneous write and read leaves fill_level unchanged.
  - m_data/m_valid are combinational from the head entry and fill_level != 0.
  - Pointers wrap modulo DEPTH. fill_level never exceeds DEPTH and never underflows.
  - m_ready while empty has no effect.
- enable=0 never blocks draining. Buffered data remains valid while idle.
- reset_n asserted mid-operation:
  - Immediately clears the FIFO, counters and FSM.
  - An outstanding request's sample is not captured.
  - The generator is reset by the same reset_n (inverted at the top level), so the sequence restarts from the seeds.

Decomposition:
- Shared package taus_pkg:
  - FSM state enum (S_IDLE, S_WARM, S_RUN).
  - Default seed constants 32'hffffffff, 32'hcccccccc, 32'h00ff00ff, shared with the generator and the bench model.
  - Sample width constant RAND_W=32.
- One sub-module: taus_fifo (DEPTH x RAND_W, synchronous write/read, combinational head, async active-low reset).
- FSM and request/credit logic stay in taus_fetch.

Test Plan:
- Release reset, enable=1, m_ready=0, WARMUP=16, DEPTH=8:
  - exactly 24 gen_rand_gen pulses; warmup_done rises on the capture of the 16th sample;
  - fill_level settles at 8 with no further requests;
  - m_data equals the 17th generator output of the bench model seeded ffffffff/cccccccc/00ff00ff.
- Continuous m_ready=1 after fill:
  - one request per cycle sustained; m_data matches the model sequence with no gaps or duplicates over 1000 samples.
- m_ready toggled randomly with enable=1:
  - fill_level stays in 0..8; no sample lost or duplicated; gen_rand_gen never issued when fill_level + req_d - pop = 8.
- enable dropped in the cycle of a request:
  - that sample is still written (fill_level +1); FSM reaches S_IDLE; re-enable resumes S_RUN without new warm-up.
- gen_rand_valid forced 0 during a capture cycle -> proto_err=1 and stays 1 until reset_n low.
- reset_n pulsed low while FIFO holds 5 entries with a request outstanding:
  - all outputs return to reset values at once;
  - after release, warm-up repeats and the first buffered sample again equals model output 17.
